// File: rtl/hh_sched_pkg.sv
// -----------------------------------------------------------------------------
// hh_sched_pkg
// Shared types and default constants for the Hodgkin-Huxley PE scheduler.
//   sched_state_t  : scheduler FSM state encoding
//   neuron_state_t : layout of one neuron's state word {v, m, h, n}; the
//                    register file stores it flattened in this same order
//   *_DEF          : reset/initial values used as parameter defaults
// -----------------------------------------------------------------------------
package hh_sched_pkg;

    localparam int HH_DW = 22;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_STORE,
        ST_SPIKE
    } sched_state_t;

    typedef struct packed {
        logic [HH_DW-1:0] v;
        logic [HH_DW-1:0] m;
        logic [HH_DW-1:0] h;
        logic [HH_DW-1:0] n;
    } neuron_state_t;

    localparam logic signed [HH_DW-1:0] V_REST_DEF   = -22'sd65;
    localparam logic        [HH_DW-1:0] M_INIT_DEF   = 22'd1;
    localparam logic        [HH_DW-1:0] H_INIT_DEF   = 22'd6;
    localparam logic        [HH_DW-1:0] N_INIT_DEF   = 22'd3;
    localparam logic signed [HH_DW-1:0] V_THRESH_DEF = 22'sd0;

endpackage

// File: rtl/hh_state_rf.sv
// -----------------------------------------------------------------------------
// hh_state_rf
// Per-neuron state file ({v,m,h,n}, 4*DW bits per entry, reset to the
// configured initial values) plus a separate injected-current file (reset 0).
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   rd_addr         : shared read index for both files (combinational read)
//   rd_state        : {v,m,h,n} of entry rd_addr
//   rd_i_inj        : I_inj of entry rd_addr
//   wr_en/addr/state: state write port
//   i_wr_en/addr/data: I_inj write port (configuration side)
// -----------------------------------------------------------------------------
module hh_state_rf
    import hh_sched_pkg::*;
#(
    parameter int              N_NEURONS = 8,
    parameter int              DW        = HH_DW,
    parameter int              AW        = 3,
    parameter logic [DW-1:0]   V_REST    = V_REST_DEF,
    parameter logic [DW-1:0]   M_INIT    = M_INIT_DEF,
    parameter logic [DW-1:0]   H_INIT    = H_INIT_DEF,
    parameter logic [DW-1:0]   N_INIT    = N_INIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     rd_addr,
    output logic [4*DW-1:0]   rd_state,
    output logic [DW-1:0]     rd_i_inj,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [4*DW-1:0]   wr_state,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DW-1:0]     i_wr_data
);

    logic [4*DW-1:0] state_arr [N_NEURONS];
    logic [DW-1:0]   i_inj_arr [N_NEURONS];

    // Each entry owns its registers so that the reset value can be loaded
    // into every entry at once.
    genvar gi;
    generate
        for (gi = 0; gi < N_NEURONS; gi++) begin : g_entry
            logic [4*DW-1:0] state_reg;
            logic [DW-1:0]   i_inj_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    state_reg <= {V_REST, M_INIT, H_INIT, N_INIT};
                    i_inj_reg <= '0;
                end else begin
                    if (wr_en && (wr_addr == AW'(gi)))
                        state_reg <= wr_state;
                    if (i_wr_en && (i_wr_addr == AW'(gi)))
                        i_inj_reg <= i_wr_data;
                end
            end

            assign state_arr[gi] = state_reg;
            assign i_inj_arr[gi] = i_inj_reg;
        end
    endgenerate

    assign rd_state = state_arr[rd_addr];
    assign rd_i_inj = i_inj_arr[rd_addr];

endmodule

// File: rtl/hh_pe_scheduler.sv
// -----------------------------------------------------------------------------
// hh_pe_scheduler
// Time-multiplexes one Hodgkin-Huxley PE over N_NEURONS virtual neurons. Each
// tick runs LOAD -> ISSUE -> WAIT -> STORE for neurons 0..N_NEURONS-1 and
// reports upward threshold crossings of V as spike events (valid/ready).
// Optional feature macro: HH_SCHED_WATCHDOG_EN adds a WAIT watchdog
// (TIMEOUT parameter, sticky pe_err output).
// Ports:
//   clk, reset                  : clock, asynchronous active-low reset
//   tick                        : start one integration step
//   busy, overrun               : step in progress / sticky tick-while-busy
//   cfg_we, cfg_addr, cfg_data  : I_inj register file write
//   pe_start, pe_*_in           : PE launch pulse and held operands
//   pe_done, pe_*_out           : PE completion pulse and results
//   spike_valid/id/ready        : spike event handshake
//   cur_idx                     : neuron currently being processed
//   pe_err (watchdog only)      : sticky PE timeout flag
// -----------------------------------------------------------------------------
module hh_pe_scheduler
    import hh_sched_pkg::*;
#(
    parameter int                    N_NEURONS = 8,
    parameter int                    DW        = HH_DW,
    parameter int                    AW        = 3,
    parameter logic signed [DW-1:0]  V_REST    = V_REST_DEF,
    parameter logic        [DW-1:0]  M_INIT    = M_INIT_DEF,
    parameter logic        [DW-1:0]  H_INIT    = H_INIT_DEF,
    parameter logic        [DW-1:0]  N_INIT    = N_INIT_DEF,
    parameter logic signed [DW-1:0]  V_THRESH  = V_THRESH_DEF
`ifdef HH_SCHED_WATCHDOG_EN
    ,
    parameter int                    TIMEOUT   = 255
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    output logic            busy,
    output logic            overrun,
    input  logic            cfg_we,
    input  logic [AW-1:0]   cfg_addr,
    input  logic [DW-1:0]   cfg_data,
    output logic            pe_start,
    output logic [DW-1:0]   pe_v_in,
    output logic [DW-1:0]   pe_m_in,
    output logic [DW-1:0]   pe_h_in,
    output logic [DW-1:0]   pe_n_in,
    output logic [DW-1:0]   pe_i_in,
    input  logic            pe_done,
    input  logic [DW-1:0]   pe_v_out,
    input  logic [DW-1:0]   pe_m_out,
    input  logic [DW-1:0]   pe_h_out,
    input  logic [DW-1:0]   pe_n_out,
    output logic            spike_valid,
    output logic [AW-1:0]   spike_id,
    input  logic            spike_ready,
    output logic [AW-1:0]   cur_idx
`ifdef HH_SCHED_WATCHDOG_EN
    ,
    output logic            pe_err
`endif
);

    sched_state_t    state_reg, state_next;
    logic [AW-1:0]   idx_reg;
    logic            busy_reg, overrun_reg;
    logic            spike_valid_reg;
    logic [AW-1:0]   spike_id_reg;
    logic [DW-1:0]   v_in_reg, m_in_reg, h_in_reg, n_in_reg, i_in_reg;
    logic [DW-1:0]   v_res_reg, m_res_reg, h_res_reg, n_res_reg;
    logic [4*DW-1:0] rd_state;
    logic [DW-1:0]   rd_i_inj;
    logic            wd_expire;   // WAIT abandoned this cycle
    logic            skip_store;  // current STORE has no valid PE result
    logic            crossing, spike_stall, last_idx;

    hh_state_rf #(
        .N_NEURONS (N_NEURONS),
        .DW        (DW),
        .AW        (AW),
        .V_REST    (V_REST),
        .M_INIT    (M_INIT),
        .H_INIT    (H_INIT),
        .N_INIT    (N_INIT)
    ) u_rf (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (idx_reg),
        .rd_state  (rd_state),
        .rd_i_inj  (rd_i_inj),
        .wr_en     ((state_reg == ST_STORE) && !skip_store),
        .wr_addr   (idx_reg),
        .wr_state  ({v_res_reg, m_res_reg, h_res_reg, n_res_reg}),
        .i_wr_en   (cfg_we),
        .i_wr_addr (cfg_addr),
        .i_wr_data (cfg_data)
    );

    assign last_idx = (idx_reg == AW'(N_NEURONS - 1));

    // V_old is still held in the operand register during STORE.
    assign crossing    = !skip_store
                         && ($signed(v_in_reg)  <  V_THRESH)
                         && ($signed(v_res_reg) >= V_THRESH);
    // A second event cannot be queued while the first is still unaccepted.
    assign spike_stall = crossing && spike_valid_reg && !spike_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (tick) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (pe_done || wd_expire) state_next = ST_STORE;
            ST_STORE: begin
                if (spike_stall)
                    state_next = ST_SPIKE;
                else
                    state_next = last_idx ? ST_IDLE : ST_LOAD;
            end
            ST_SPIKE: if (spike_ready) state_next = last_idx ? ST_IDLE : ST_LOAD;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_reg         <= '0;
            busy_reg        <= 1'b0;
            overrun_reg     <= 1'b0;
            spike_valid_reg <= 1'b0;
            spike_id_reg    <= '0;
            v_in_reg        <= '0;
            m_in_reg        <= '0;
            h_in_reg        <= '0;
            n_in_reg        <= '0;
            i_in_reg        <= '0;
            v_res_reg       <= '0;
            m_res_reg       <= '0;
            h_res_reg       <= '0;
            n_res_reg       <= '0;
        end else begin
            // busy follows the state the FSM is entering, so it drops in the
            // cycle after the last write-back.
            busy_reg <= (state_next != ST_IDLE);
            if (tick && busy_reg)
                overrun_reg <= 1'b1;

            if ((state_reg == ST_IDLE) && tick)
                idx_reg <= '0;
            else if (((state_reg == ST_STORE) || (state_reg == ST_SPIKE))
                     && (state_next == ST_LOAD))
                idx_reg <= idx_reg + AW'(1);

            if (state_reg == ST_LOAD) begin
                {v_in_reg, m_in_reg, h_in_reg, n_in_reg} <= rd_state;
                i_in_reg <= rd_i_inj;
            end

            // PE results are only valid during pe_done; hold them for STORE.
            if ((state_reg == ST_WAIT) && pe_done) begin
                v_res_reg <= pe_v_out;
                m_res_reg <= pe_m_out;
                h_res_reg <= pe_h_out;
                n_res_reg <= pe_n_out;
            end

            if ((state_reg == ST_STORE) && crossing && !spike_stall) begin
                spike_valid_reg <= 1'b1;
                spike_id_reg    <= idx_reg;
            end else if ((state_reg == ST_SPIKE) && spike_ready) begin
                // Pending event leaves, stalled event takes its place.
                spike_id_reg    <= idx_reg;
            end else if (spike_valid_reg && spike_ready) begin
                spike_valid_reg <= 1'b0;
            end
        end
    end

`ifdef HH_SCHED_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT + 1);

    logic [WDW-1:0] wd_cnt_reg;
    logic           wd_to_reg;
    logic           pe_err_reg;

    // After TIMEOUT WAIT cycles without pe_done the neuron is skipped.
    assign wd_expire = (state_reg == ST_WAIT) && !pe_done
                       && (wd_cnt_reg == WDW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt_reg <= '0;
            wd_to_reg  <= 1'b0;
            pe_err_reg <= 1'b0;
        end else begin
            if (state_reg == ST_ISSUE) begin
                wd_cnt_reg <= '0;
                wd_to_reg  <= 1'b0;
            end else if (state_reg == ST_WAIT) begin
                wd_cnt_reg <= wd_cnt_reg + WDW'(1);
            end
            if (wd_expire) begin
                wd_to_reg  <= 1'b1;
                pe_err_reg <= 1'b1;
            end
        end
    end

    assign skip_store = wd_to_reg;
    assign pe_err     = pe_err_reg;
`else
    assign wd_expire  = 1'b0;
    assign skip_store = 1'b0;
`endif

    assign busy        = busy_reg;
    assign overrun     = overrun_reg;
    assign pe_start    = (state_reg == ST_ISSUE);
    assign pe_v_in     = v_in_reg;
    assign pe_m_in     = m_in_reg;
    assign pe_h_in     = h_in_reg;
    assign pe_n_in     = n_in_reg;
    assign pe_i_in     = i_in_reg;
    assign spike_valid = spike_valid_reg;
    assign spike_id    = spike_id_reg;
    assign cur_idx     = idx_reg;

endmodule

// File: doc/hh_pe_scheduler.md
Name: hh_pe_scheduler

Overview:
- Time-multiplexes one shared Hodgkin-Huxley CORDIC processing element (PE) across N_NEURONS virtual neurons.
- Holds per-neuron state (V, m, h, n) and injected current I_inj in a register file.
- On each simulation tick: sequences load → PE start → wait for done → write-back for every neuron in index order.
- Detects upward threshold crossings of V and emits spike events over a valid/ready interface to the network layer.

Parameters:
- N_NEURONS, 8, number of virtual neurons; power of two, 2..64.
- DW, 22, fixed-point word width of all state, current and PE ports (two's complement).
- AW, 3, neuron index width; must equal log2(N_NEURONS).
- V_REST, -22'sd65, reset value of V for every neuron.
- M_INIT, 22'd1, reset value of m.
- H_INIT, 22'd6, reset value of h.
- N_INIT, 22'd3, reset value of n.
- V_THRESH, 22'sd0, spike threshold on V (signed).
- TIMEOUT, 255, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  single-cycle pulse; start one integration step over all neurons.
- busy  out  1  high from tick acceptance until the last neuron is written back.
- overrun  out  1  sticky; tick arrived while busy. Cleared only by reset.
- cfg_we  in  1  write enable, I_inj register file.
- cfg_addr  in  AW  neuron index for the cfg_we write.
- cfg_data  in  DW  I_inj value for the cfg_we write.
- pe_start  out  1  one-cycle pulse; PE inputs are valid in that cycle.
- pe_v_in, pe_m_in, pe_h_in, pe_n_in, pe_i_in  out  DW each  operands to the PE; held stable from pe_start until pe_done.
- pe_done  in  1  one-cycle pulse; PE results are valid in that cycle.
- pe_v_out, pe_m_out, pe_h_out, pe_n_out  in  DW each  PE results.
- spike_valid  out  1  a spike event is pending.
- spike_id  out  AW  index of the spiking neuron.
- spike_ready  in  1  consumer accepts the event when spike_valid && spike_ready.
- cur_idx  out  AW  index of the neuron being processed (debug).

Behaviour:
Reset (reset=0, async):
- All outputs 0, cur_idx 0, FSM in IDLE.
- State file: V=V_REST, m=M_INIT, h=H_INIT, n=N_INIT; I_inj file = 0.
- Reset mid-step aborts the step. Any pe_done arriving after reset deasserts is ignored in IDLE.

FSM states IDLE, LOAD, ISSUE, WAIT, STORE, SPIKE:
- IDLE: on tick → LOAD, idx=0, busy=1.
- LOAD (1 cycle): register the state and I_inj of idx into the pe_*_in operand registers.
- ISSUE (1 cycle): pe_start=1 → WAIT.
- WAIT: remain until pe_done. pe_done in the same cycle as ISSUE is impossible by the PE contract and need not be handled.
- STORE (1 cycle): write pe_*_out to entry idx.
  - crossing = (V_old < V_THRESH) && (pe_v_out >= V_THRESH), signed compare.
  - If crossing and spike_valid is already high and not being accepted this cycle → SPIKE (stall, no index advance).
  - Else, if crossing: set spike_valid, spike_id=idx.
  - Then: if idx==N_NEURONS-1 → IDLE, busy=0 on the next cycle; else idx+1 → LOAD.
- SPIKE: wait for the pending event to be accepted, load the new event, then take the STORE-exit transition.
- Latency per neuron = 3 + PE latency cycles (plus any SPIKE stall).

spike handshake:
- spike_valid, once set, holds with spike_id unchanged until accepted.
- Accept and a new spike in the same cycle: the new event is loaded with no bubble.

tick handling:
- tick while busy: tick dropped, overrun set.
- tick in the same cycle as the busy-clearing transition counts as busy → overrun.

cfg writes:
- Accepted in any state.
- cfg_addr is always in range, since N_NEURONS is a power of two.
- A write to idx after its LOAD takes effect in the next step.

Arithmetic:
- No arithmetic beyond the threshold compare and the index increment.
- Index increment wraps modulo N_NEURONS; wrap is never used because the step ends at N_NEURONS-1.

Optional Feature:
- Macro HH_SCHED_WATCHDOG_EN.
- With it:
  - Counter cleared at ISSUE, incremented each WAIT cycle.
  - On reaching TIMEOUT: state of idx left unchanged, output pe_err (1 bit, sticky until reset) set, FSM proceeds as if STORE with no crossing.
- Without it: WAIT waits indefinitely, no pe_err port, no counter logic.

Decomposition:
- Package hh_sched_pkg:
  - FSM state enum.
  - neuron_state_t struct {V, m, h, n} of DW each.
  - Default init constants.
- Sub-module hh_state_rf: N_NEURONS×(4·DW) register file with reset init, one read port, one write port; plus a separate I_inj file with its own write port.

Test Plan:
- Reset, then tick with PE model done after 5 cycles, N=8 → busy high exactly 8×(3+5)=64 cycles; 8 pe_start pulses with cur_idx 0..7; state written back matches the model outputs.
- Model returns V=+10 for neuron 3 only (old V=-65) → spike_valid with spike_id=3; held for 4 cycles with spike_ready=0, then accepted; no duplicate event.
- Neurons 2 and 3 cross while spike_ready=0 → FSM enters SPIKE and stalls; after ready: ids 2 then 3 delivered in order; busy extended by the stall length.
- tick asserted twice mid-step → overrun=1, only one step executed, overrun stays 1 until reset.
- cfg_we addr=5 data=4 before tick → pe_i_in=4 at neuron 5's pe_start; reset pulsed during WAIT of neuron 2 → all outputs 0 and V reads back V_REST.
- With HH_SCHED_WATCHDOG_EN and TIMEOUT=20, PE never asserts done for neuron 1 → pe_err=1 after 20 cycles, neuron 1 state unchanged, step completes through neuron 7.
